w4_unpack_stage: RTL

- Downstream consumer of the 256-bit word stream produced by the weight width-divider in the W4A8 GEMM datapath.
- Each input word holds 64 packed int4 weights. The block expands them to int8, optionally subtracting a per-group zero-point, and emits two 256-bit beats (32 int8 lanes each) to the GEMM PE array.
- It frames a programmed number of words per ap_start, flags the last beat, and pulses done.

---
 rtl/w4a8_pkg.sv | 30 +++
 rtl/w4_nibble_conv.sv | 19 +
 rtl/w4_unpack_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/w4a8_pkg.sv
// Shared types and the int4 -> int8 conversion for the W4A8 weight unpack path.
package w4a8_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned INT8_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        ZP_WAIT,
        LOAD,
        EMIT,
        DONE
    } state_e;

    // mode 0: signed int4; mode 1: unsigned nibble minus zero-point (range -15..15, no overflow)
    function automatic logic [INT8_W-1:0] int4_to_int8(
        input logic [NIBBLE_W-1:0] nib,
        input logic [NIBBLE_W-1:0] zp,
        input logic                mode
    );
        logic [INT8_W-1:0] res;
        if (mode) begin
            res = {4'b0000, nib} - {4'b0000, zp};
        end else begin
            res = {{4{nib[3]}}, nib};
        end
        return res;
    endfunction

endpackage

// File: rtl/w4_nibble_conv.sv
// Combinational LANES-wide int4 -> int8 expander.
module w4_nibble_conv
    import w4a8_pkg::*;
#(
    parameter int unsigned LANES = 32
) (
    input  logic [LANES*NIBBLE_W-1:0] nib_vec,
    input  logic [NIBBLE_W-1:0]       zp,
    input  logic                      mode,
    output logic [LANES*INT8_W-1:0]   int8_vec
);

    // One converter per output lane
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign int8_vec[k*INT8_W +: INT8_W] =
            int4_to_int8(nib_vec[k*NIBBLE_W +: NIBBLE_W], zp, mode);
    end

endmodule

// File: rtl/w4_unpack_stage.sv
// Unpacks 256-bit int4 weight words into two int8 beats per word, with optional
// per-group zero-point subtraction, framed by ap_start / last_out / done.
module w4_unpack_stage
    import w4a8_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = 256,
    parameter int unsigned LANES       = IN_WIDTH / 8,
    parameter int unsigned GROUP_BEATS = 2,
    parameter int unsigned LEN_W       = 16
) (
    input  logic                clk,
    input  logic                areset_n,
    input  logic                ap_start,
    input  logic [LEN_W-1:0]    num_words,
    input  logic                zp_mode,
    input  logic [IN_WIDTH-1:0] wt_data_in,
    input  logic                wt_valid_in,
    output logic                wt_ready_out,
    input  logic [3:0]          zp_in,
    input  logic                zp_valid_in,
    output logic                zp_ready_out,
    output logic [IN_WIDTH-1:0] data_out,
    output logic                valid_out,
    output logic                last_out,
    input  logic                ready_in,
    output logic                done
);

    localparam int unsigned HALF_W = IN_WIDTH / 2;
    localparam int unsigned GRP_W  = (GROUP_BEATS > 1) ? $clog2(GROUP_BEATS) : 1;

    state_e              state_q;
    logic [IN_WIDTH-1:0] buf_q;
    logic [3:0]          zp_q;
    logic                phase_q;
    logic [LEN_W-1:0]    word_cnt_q;
    logic [LEN_W-1:0]    num_words_q;
    logic [GRP_W-1:0]    grp_cnt_q;
    logic                zp_mode_q;

    logic                is_final;
    logic                grp_wrap;
    logic                out_fire;
    logic                wt_fire;
    logic                zp_fire;
    logic [HALF_W-1:0]   half_sel;
    logic [IN_WIDTH-1:0] conv_out;

    // Frame position decode and handshakes
    always_comb begin
        is_final     = (word_cnt_q == (num_words_q - LEN_W'(1)));
        grp_wrap     = (grp_cnt_q == GRP_W'(GROUP_BEATS - 1));
        valid_out    = (state_q == EMIT);
        zp_ready_out = (state_q == ZP_WAIT);
        done         = (state_q == DONE);
        last_out     = valid_out & phase_q & is_final;
        // Ready during the second beat lets the next word load with no bubble
        wt_ready_out = (state_q == LOAD) |
                       (valid_out & phase_q & ready_in & ~is_final & ~(grp_wrap & zp_mode_q));
        out_fire     = valid_out & ready_in;
        wt_fire      = wt_valid_in & wt_ready_out;
        zp_fire      = zp_valid_in & zp_ready_out;
        half_sel     = phase_q ? buf_q[IN_WIDTH-1:HALF_W] : buf_q[HALF_W-1:0];
        data_out     = valid_out ? conv_out : '0;
    end

    w4_nibble_conv #(
        .LANES (LANES)
    ) u_conv (
        .nib_vec  (half_sel),
        .zp       (zp_q),
        .mode     (zp_mode_q),
        .int8_vec (conv_out)
    );

    // Frame FSM; ap_start overrides every state and drops any in-flight beat
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            zp_q        <= '0;
            phase_q     <= 1'b0;
            word_cnt_q  <= '0;
            num_words_q <= '0;
            grp_cnt_q   <= '0;
            zp_mode_q   <= 1'b0;
        end else if (ap_start) begin
            num_words_q <= num_words;
            zp_mode_q   <= zp_mode;
            buf_q       <= '0;
            phase_q     <= 1'b0;
            word_cnt_q  <= '0;
            grp_cnt_q   <= '0;
            if (num_words == '0) begin
                state_q <= DONE;
            end else if (zp_mode) begin
                state_q <= ZP_WAIT;
            end else begin
                state_q <= LOAD;
            end
        end else begin
            case (state_q)
                IDLE: ;
                ZP_WAIT: begin
                    if (zp_fire) begin
                        zp_q    <= zp_in;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (wt_fire) begin
                        buf_q   <= wt_data_in;
                        phase_q <= 1'b0;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (!phase_q) begin
                            phase_q <= 1'b1;
                        end else begin
                            word_cnt_q <= word_cnt_q + LEN_W'(1);
                            grp_cnt_q  <= grp_wrap ? '0 : grp_cnt_q + GRP_W'(1);
                            if (is_final) begin
                                state_q <= DONE;
                            end else if (grp_wrap && zp_mode_q) begin
                                state_q <= ZP_WAIT;
                            end else if (wt_valid_in) begin
                                buf_q   <= wt_data_in;
                                phase_q <= 1'b0;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
